// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode codes and the transmitter state encoding.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo1_if.sv
// Valid/ready word handshake between a byte producer and the UART transmitter.
interface uart_tx_fifo1_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic [WIDTH-1:0] i_data;
  logic             i_valid;
  logic             o_ready;

  modport master (output i_data, output i_valid, input o_ready);
  modport slave  (input i_data, input i_valid, output o_ready);

endinterface

// File: rtl/uart_baud_cnt.sv
// Loadable bit timer: latches a divisor (clamped to >= 2) and strobes on the last cycle of each bit.
module uart_baud_cnt #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 i_reset_n,
  input  logic                 i_load,
  input  logic                 i_run,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic                 o_expire_c
);

  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_eff_c;

  assign div_eff_c  = (i_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : i_div;
  assign o_expire_c = i_run && (cnt_q == '0);

  // Load wins over counting so a back-to-back frame picks up the new divisor on its first cycle.
  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    if (i_load) begin
      div_d = div_eff_c;
      cnt_d = div_eff_c - DIV_WIDTH'(1);
    end else if (i_run) begin
      if (cnt_q == '0) begin
        cnt_d = div_q - DIV_WIDTH'(1);
      end else begin
        cnt_d = cnt_q - DIV_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      div_q <= DIV_WIDTH'(2);
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo1.sv
// UART transmitter with a one-word holding buffer so consecutive frames leave with no idle gap.
module uart_tx_fifo1
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIV_WIDTH = 16,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 i_reset_n,
  input  logic [DIV_WIDTH-1:0] i_div,
  uart_tx_fifo1_if.slave       tx_if,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int unsigned IDX_W = 4;

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic [WIDTH-1:0] word_c;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             par_q, par_d;
  logic             ready_q, ready_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept_c, expire_c, start_c, last_stop_c;

  uart_baud_cnt #(.DIV_WIDTH(DIV_WIDTH)) u_baud_cnt (
    .clk        (clk),
    .i_reset_n  (i_reset_n),
    .i_load     (start_c),
    .i_run      (state_q != ST_IDLE),
    .i_div      (i_div),
    .o_expire_c (expire_c)
  );

  assign accept_c    = tx_if.i_valid && ready_q;
  assign last_stop_c = (state_q == ST_STOP) && expire_c && (idx_q == IDX_W'(STOP_BITS - 1));

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    par_d   = par_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    start_c = 1'b0;
    word_c  = tx_if.i_data;
    tx_d    = 1'b1;
    busy_d  = 1'b0;

    // Mid-frame words park in the buffer; on the frame-end edge they go straight to the shifter.
    if (accept_c && (state_q != ST_IDLE) && !last_stop_c) begin
      buf_d   = tx_if.i_data;
      ready_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: start_c = accept_c;
      ST_START: begin
        if (expire_c) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (expire_c) begin
          shift_d = (LSB_FIRST != 0) ? (shift_q >> 1) : (shift_q << 1);
          if (idx_q == IDX_W'(WIDTH - 1)) begin
            idx_d   = '0;
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (expire_c) begin
          state_d = ST_STOP;
          idx_d   = '0;
        end
      end
      ST_STOP: begin
        if (last_stop_c) begin
          done_d = 1'b1;
          if (!ready_q) begin
            start_c = 1'b1;
            word_c  = buf_q;
            ready_d = 1'b1;
          end else if (accept_c) begin
            start_c = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (expire_c) begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_c) begin
      state_d = ST_START;
      shift_d = word_c;
      idx_d   = '0;
      par_d   = (PARITY == PAR_ODD) ? ~^word_c : ^word_c;
    end

    // Line and busy are registered from the next state so they line up with the FSM.
    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = (LSB_FIRST != 0) ? shift_d[0] : shift_d[WIDTH-1];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      buf_q   <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      ready_q <= 1'b1;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      ready_q <= ready_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx_if.o_ready = ready_q;
  assign o_tx          = tx_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;

endmodule

// File: tb/tb_uart_tx_fifo1.sv
// Bench for uart_tx_fifo1: three parameter sets checked against a frame-level line model.
module tb_uart_tx_fifo1;

  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic [DW-1:0] div0, div1, div2;
  logic tx0, busy0, done0, tx1, busy1, done1, tx2, busy2, done2;

  always #5 clk = ~clk;

  uart_tx_fifo1_if #(.WIDTH(8)) if0 ();
  uart_tx_fifo1_if #(.WIDTH(8)) if1 ();
  uart_tx_fifo1_if #(.WIDTH(8)) if2 ();

  uart_tx_fifo1 #(.WIDTH(8), .DIV_WIDTH(DW), .PARITY(1), .STOP_BITS(1), .LSB_FIRST(1)) dut0 (
    .clk(clk), .i_reset_n(rst_n), .i_div(div0), .tx_if(if0), .o_tx(tx0), .o_busy(busy0), .o_done(done0));
  uart_tx_fifo1 #(.WIDTH(8), .DIV_WIDTH(DW), .PARITY(2), .STOP_BITS(2), .LSB_FIRST(1)) dut1 (
    .clk(clk), .i_reset_n(rst_n), .i_div(div1), .tx_if(if1), .o_tx(tx1), .o_busy(busy1), .o_done(done1));
  uart_tx_fifo1 #(.WIDTH(8), .DIV_WIDTH(DW), .PARITY(0), .STOP_BITS(1), .LSB_FIRST(0)) dut2 (
    .clk(clk), .i_reset_n(rst_n), .i_div(div2), .tx_if(if2), .o_tx(tx2), .o_busy(busy2), .o_done(done2));

  int checks = 0;
  int errors = 0;
  int cur_div [3];

  // Frame format of each instance.
  function automatic int pw(input int k);    return 8; endfunction
  function automatic int ppar(input int k);  return (k == 0) ? 1 : (k == 1) ? 2 : 0; endfunction
  function automatic int pstop(input int k); return (k == 1) ? 2 : 1; endfunction
  function automatic bit plsb(input int k);  return (k != 2); endfunction

  function automatic logic get_tx(input int k);
    case (k) 0: return tx0; 1: return tx1; default: return tx2; endcase
  endfunction
  function automatic logic get_busy(input int k);
    case (k) 0: return busy0; 1: return busy1; default: return busy2; endcase
  endfunction
  function automatic logic get_done(input int k);
    case (k) 0: return done0; 1: return done1; default: return done2; endcase
  endfunction
  function automatic logic get_ready(input int k);
    case (k) 0: return if0.o_ready; 1: return if1.o_ready; default: return if2.o_ready; endcase
  endfunction

  task automatic set_drive(input int k, input logic [7:0] w, input logic v);
    case (k)
      0: begin if0.i_data = w; if0.i_valid = v; end
      1: begin if1.i_data = w; if1.i_valid = v; end
      default: begin if2.i_data = w; if2.i_valid = v; end
    endcase
  endtask

  task automatic set_div(input int k, input int d);
    cur_div[k] = d;
    case (k)
      0: div0 = DW'(d);
      1: div1 = DW'(d);
      default: div2 = DW'(d);
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Line capture: tx while busy, busy-cycle count at each done pulse, idle-line violations.
  bit cap_en = 1'b0;
  int sel = 0;
  bit got_q[$];
  int done_at[$];
  int busy_cnt, cyc, first_busy, last_busy, idle_bad;
  bit exp_q[$];
  int exp_done[$];
  int cum_len;

  always @(negedge clk) begin
    if (cap_en) begin
      if (get_done(sel) === 1'b1) done_at.push_back(busy_cnt);
      if (get_busy(sel) === 1'b1) begin
        if (busy_cnt == 0) first_busy = cyc;
        last_busy = cyc;
        got_q.push_back(get_tx(sel));
        busy_cnt++;
      end else if (get_tx(sel) !== 1'b1) begin
        idle_bad++;
      end
      cyc++;
    end
  end

  task automatic clear_cap();
    got_q.delete(); done_at.delete(); exp_q.delete(); exp_done.delete();
    busy_cnt = 0; cyc = 0; first_busy = 0; last_busy = 0; idle_bad = 0; cum_len = 0;
  endtask

  // Reference: the frame as a bit list, each bit stretched to the effective divisor.
  function automatic void push_frame(input int k, input logic [7:0] w, input int div);
    int eff;
    int ones;
    bit fb[$];
    eff  = (div < 2) ? 2 : div;
    ones = 0;
    fb.push_back(1'b0);
    for (int i = 0; i < pw(k); i++) begin
      int idx;
      idx = plsb(k) ? i : pw(k) - 1 - i;
      fb.push_back(w[idx]);
      ones += int'(w[i]);
    end
    if (ppar(k) == 1) fb.push_back((ones % 2) == 1);
    if (ppar(k) == 2) fb.push_back((ones % 2) == 0);
    for (int s = 0; s < pstop(k); s++) fb.push_back(1'b1);
    foreach (fb[i]) repeat (eff) exp_q.push_back(fb[i]);
    cum_len += fb.size() * eff;
    exp_done.push_back(cum_len);
  endfunction

  task automatic send(input int k, input logic [7:0] w, output int waited);
    set_drive(k, w, 1'b1);
    waited = 0;
    while (get_ready(k) !== 1'b1 && waited <= 4000) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited > 4000) chk("send_accept", 32'(get_ready(k)), 1);
    @(posedge clk); #1;
    set_drive(k, w, 1'b0);
    push_frame(k, w, cur_div[k]);
  endtask

  task automatic end_window(input string tag, input bit contig);
    int idle_run;
    int n;
    int nbad;
    idle_run = 0;
    n = 0;
    while (idle_run < 3 && n < 5000) begin
      @(posedge clk); #1;
      n++;
      if (get_busy(sel) === 1'b0) idle_run++; else idle_run = 0;
    end
    chk({tag, "_idle_reached"}, 32'(idle_run), 3);
    chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    nbad = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] != exp_q[i]) nbad++;
    chk({tag, "_bits_bad"}, 32'(nbad), 0);
    chk({tag, "_done_n"}, 32'(done_at.size()), 32'(exp_done.size()));
    nbad = 0;
    for (int i = 0; i < done_at.size() && i < exp_done.size(); i++) if (done_at[i] != exp_done[i]) nbad++;
    chk({tag, "_done_pos_bad"}, 32'(nbad), 0);
    chk({tag, "_idle_line_bad"}, 32'(idle_bad), 0);
    if (contig) chk({tag, "_gap"}, 32'(last_busy - first_busy + 1), 32'(busy_cnt));
  endtask

  task automatic start_window(input int k);
    cap_en = 1'b0;
    clear_cap();
    sel = k;
    cap_en = 1'b1;
  endtask

  initial begin
    int w;
    int nbad;
    bit pat[11];
    pat = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_drive(k, 8'h00, 1'b0);
      set_div(k, 4);
    end
    clear_cap();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx0), 1);
    chk("rst_ready", 32'(if0.o_ready), 1);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_done", 32'(done0), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 0xA5, even parity, div 4.
    start_window(0);
    send(0, 8'hA5, w);
    chk("lat_tx", 32'(tx0), 0);
    chk("lat_busy", 32'(busy0), 1);
    end_window("a5", 1'b1);
    chk("a5_total", 32'(got_q.size()), 44);
    nbad = 0;
    for (int i = 0; i < 11; i++) if (4 * i >= got_q.size() || got_q[4 * i] != pat[i]) nbad++;
    chk("a5_pattern_bad", 32'(nbad), 0);

    // Back-to-back with a third word held until the first frame ends.
    start_window(0);
    send(0, 8'h00, w);
    send(0, 8'hFF, w);
    chk("buf_full_ready", 32'(if0.o_ready), 0);
    send(0, 8'h3C, w);
    chk("third_wait", 32'(w), 43);
    end_window("b2b", 1'b1);

    // Odd parity, two stop bits, div 3.
    set_div(1, 3);
    start_window(1);
    send(1, 8'h01, w);
    end_window("odd2", 1'b1);
    chk("odd2_total", 32'(got_q.size()), 36);
    if (got_q.size() > 27) chk("odd2_parity", 32'(got_q[27]), 0);

    // MSB first, no parity.
    start_window(2);
    send(2, 8'h80, w);
    end_window("msb", 1'b1);
    chk("msb_total", 32'(got_q.size()), 40);
    if (got_q.size() > 8) begin
      chk("msb_first", 32'(got_q[4]), 1);
      chk("msb_second", 32'(got_q[8]), 0);
    end

    // Divisors 0 and 1 clamp to 2.
    set_div(0, 0);
    start_window(0);
    send(0, 8'($urandom), w);
    end_window("div0", 1'b1);
    chk("div0_total", 32'(got_q.size()), 22);
    set_div(0, 1);
    start_window(0);
    send(0, 8'($urandom), w);
    end_window("div1", 1'b1);
    chk("div1_total", 32'(got_q.size()), 22);

    // Divisor change mid-frame applies only to the next frame.
    set_div(0, 4);
    start_window(0);
    send(0, 8'h5A, w);
    repeat (10) begin @(posedge clk); #1; end
    set_div(0, 8);
    send(0, 8'hC3, w);
    end_window("divchg", 1'b1);
    chk("divchg_total", 32'(got_q.size()), 44 + 88);

    // Handshake exactly on the frame-end edge with the buffer empty.
    set_div(0, 3);
    start_window(0);
    send(0, 8'h96, w);
    repeat (32) begin @(posedge clk); #1; end
    send(0, 8'h69, w);
    chk("edge_wait", 32'(w), 0);
    end_window("edge", 1'b1);

    // Random words, divisors and gaps on every instance.
    for (int k = 0; k < 3; k++) begin
      for (int b = 0; b < 2; b++) begin
        set_div(k, int'($urandom_range(0, 6)));
        start_window(k);
        for (int j = 0; j < 6; j++) begin
          send(k, 8'($urandom), w);
          repeat ($urandom_range(0, 30)) begin @(posedge clk); #1; end
        end
        end_window($sformatf("rnd%0d_%0d", k, b), 1'b0);
      end
    end

    // Asynchronous reset during DATA with the buffer full.
    set_div(0, 4);
    cap_en = 1'b0;
    send(0, 8'h00, w);
    send(0, 8'h55, w);
    repeat (10) begin @(posedge clk); #1; end
    chk("pre_rst_tx", 32'(tx0), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx", 32'(tx0), 1);
    chk("arst_ready", 32'(if0.o_ready), 1);
    chk("arst_busy", 32'(busy0), 0);
    @(negedge clk) rst_n = 1'b1;
    start_window(0);
    repeat (60) begin @(posedge clk); #1; end
    chk("post_rst_busy_cycles", 32'(busy_cnt), 0);
    chk("post_rst_done", 32'(done_at.size()), 0);
    chk("post_rst_idle_line", 32'(idle_bad), 0);
    cap_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo1.md
# uart_tx_fifo1

Parametrised UART transmitter, next generation of the team's fixed-format TX block. Serialises WIDTH-bit words with optional parity, one or two stop bits, selectable bit order and a runtime baud divisor. Words arrive on a valid/ready handshake and pass through a one-entry holding buffer, so frames go out back-to-back with no idle gap. Sits between a byte-stream producer (command encoder, DMA) and the board TX pin.

## Interface
- WIDTH, 8, data bits per frame (5..9)
- DIV_WIDTH, 16, width of the runtime divisor input
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, number of stop bits (1 or 2)
- LSB_FIRST, 1, 1 = send LSB first, 0 = send MSB first
- clk  in  1  system clock; the block has one clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_div  in  DIV_WIDTH  clock cycles per bit; latched at frame start
- i_data  in  WIDTH  word to send
- i_valid  in  1  i_data valid
- o_ready  out  1  holding buffer empty; a word is accepted on any rising edge with i_valid && o_ready
- o_tx  out  1  serial line, idle high, registered
- o_busy  out  1  frame in progress (START through last STOP cycle)
- o_done  out  1  one-cycle pulse on frame completion

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP. PARITY is skipped when PARITY=0.
- Transitions occur when the bit counter expires: START→DATA; DATA→(PARITY|STOP) after WIDTH bits; PARITY→STOP; STOP→START if the buffer is full (or a word is accepted on that edge), else IDLE, after STOP_BITS stop bits.
- IDLE with a word accepted: word loads directly into the shifter, state→START on the same edge; buffer stays empty.
- Busy with a word accepted: word goes into the holding buffer; o_ready falls. At frame end the buffer moves into the shifter and o_ready rises on that same edge.
- Parity computed over the WIDTH data bits at load: even = XOR of bits, odd = XNOR.
- Divisor: i_div latched into the bit counter at every frame start; values 0 and 1 are treated as 2. i_div changes mid-frame have no effect.
- o_tx: 0 in START, current shifter bit in DATA, parity bit in PARITY, 1 in STOP and IDLE.

## Timing
- Reset values: o_tx=1, o_ready=1, o_busy=0, o_done=0, state IDLE, buffer empty. Reset acts immediately (asynchronous).
- Reset mid-frame: frame aborted, line returns high, buffered word discarded.
- Latency: handshake at edge E0 in IDLE → o_tx=0 and o_busy=1 during the cycle after E0.
- Every bit lasts exactly div cycles. Frame length = div × (1 + WIDTH + (PARITY≠0) + STOP_BITS).
- o_done is high for the single cycle following the last stop-bit cycle. When a buffered word follows, that cycle is also the first START cycle, and o_busy stays 1 throughout.
- Handshake on the frame-end edge with the buffer empty: the new word starts a frame on that edge, with no IDLE cycle.
- o_ready depends only on buffer state, never combinationally on i_valid.

## Structure
- Shared package uart_pkg: parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) and the tx_state_t enum, reused by the future RX block.
- One sub-module: uart_baud_cnt. This is a loadable down-counter with clamp-to-2 and an expiry strobe. It is also the bit timer for the RX block.
- Top level holds the FSM, shifter, bit-index counter, holding buffer and output register.

## Test plan
- WIDTH=8, PARITY=1, STOP_BITS=1, i_div=4, send 0xA5 → o_tx bits 0,1,0,1,0,0,1,0,1,0,1, each bit 4 cycles, 44 cycles total; o_done pulses once.
- Send 0x00 then 0xFF on consecutive cycles; hold a third word valid → both accepted, and the third waits with o_ready=0 until the 0x00 frame ends. The 0xFF start bit directly follows the 0x00 stop bit, with no high gap.
- PARITY=2, STOP_BITS=2, i_div=3, send 0x01 → parity bit 0, two stop bits, 36-cycle frame.
- LSB_FIRST=0, PARITY=0, send 0x80 → first data bit 1, remaining seven 0.
- i_div=0 and i_div=1 → each bit lasts 2 cycles. Change i_div from 4 to 8 mid-frame → frame keeps 4-cycle bits, and the next frame uses 8.
- Deassert i_reset_n during DATA with the buffer full → o_tx=1, o_ready=1, o_busy=0 immediately. After release, no frame is sent without a new handshake.
